// File: rtl/receive_all_pkg.sv
// Shared definitions for the interboard Request/Ack link (sender and receiver).
package receive_all_pkg;

  // Assembler step encoding, shared with the peer's sender.
  typedef enum logic [2:0] {
    STEP_1 = 3'd0,
    STEP_2 = 3'd1,
    STEP_3 = 3'd2,
    STEP_4 = 3'd3,
    STEP_5 = 3'd4,
    STEP_6 = 3'd5
  } step_t;

  // Single-word responder states.
  typedef enum logic [1:0] {
    WAIT_REQ_UP = 2'd0,
    ACK_HIGH    = 2'd1,
    ACK_LOW     = 2'd2
  } resp_state_t;

  localparam int unsigned WORD_W = 6;
  localparam logic [WORD_W-1:0] RST_WORD = 6'h3F;

  localparam int unsigned MSG_W  = 4;
  localparam int unsigned BX_W   = 5;
  localparam int unsigned BY_W   = 3;
  localparam int unsigned CARD_W = 6;
  localparam int unsigned LEN_W  = 3;

endpackage

// File: rtl/receive_single.sv
// Responder for one 6-bit word of the 4-phase Request/Ack handshake.
module receive_single
  import receive_all_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Request,
  input  logic [WORD_W-1:0] interboard_data,
  output logic              Ack,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [CNT_W-1:0]       settle_q, settle_d;
  resp_state_t            state_q, state_d;
  logic                   capture;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous Request through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], Request};
  end

  // Next state: settle count only runs while waiting, and clears on any low req_s.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    capture  = 1'b0;
    case (state_q)
      WAIT_REQ_UP: begin
        if (req_s) begin
          if (settle_q == CNT_W'(SETTLE_CYCLES)) begin
            capture = 1'b1;
            state_d = ACK_HIGH;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      ACK_HIGH: if (!req_s) state_d = ACK_LOW;
      ACK_LOW:  state_d = WAIT_REQ_UP;
      default:  state_d = WAIT_REQ_UP;
    endcase
  end

  // State, settle counter, registered Ack, captured word and its strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_REQ_UP;
      settle_q   <= '0;
      Ack        <= 1'b0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      Ack        <= (state_d == ACK_HIGH);
      word_valid <= capture;
      if (capture) word <= interboard_data;
    end
  end

endmodule

// File: rtl/receive_all.sv
// Interboard receiver: assembles six handshaken words into one GameControl message.
module receive_all
  import receive_all_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Request,
  input  logic [WORD_W-1:0] interboard_data,
  output logic              Ack,
  output logic              recv_valid,
  output logic [MSG_W-1:0]  recv_msg_type,
  output logic [BX_W-1:0]   recv_block_x,
  output logic [BY_W-1:0]   recv_block_y,
  output logic [CARD_W-1:0] recv_card,
  output logic [LEN_W-1:0]  recv_sel_len,
  output logic              recv_move_dir,
  output logic              remote_rst
);

  logic              word_valid;
  logic [WORD_W-1:0] word;

  receive_single #(
    .SYNC_STAGES  (SYNC_STAGES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_single (
    .clk            (clk),
    .rst            (rst),
    .Request        (Request),
    .interboard_data(interboard_data),
    .Ack            (Ack),
    .word_valid     (word_valid),
    .word           (word)
  );

  step_t             step_q, step_d;
  logic              is_rst_word;
  logic              msg_done;
  logic [MSG_W-1:0]  stg_msg_type;
  logic [BX_W-1:0]   stg_block_x;
  logic [BY_W-1:0]   stg_block_y;
  logic [CARD_W-1:0] stg_card;
  logic [LEN_W-1:0]  stg_sel_len;

  // Assembler next step; the reset word overrides normal advancing.
  always_comb begin
    step_d      = step_q;
    msg_done    = 1'b0;
    is_rst_word = word_valid && (word == RST_WORD);
    if (is_rst_word) begin
      step_d = STEP_1;
    end else if (word_valid) begin
      case (step_q)
        STEP_1:  step_d = STEP_2;
        STEP_2:  step_d = STEP_3;
        STEP_3:  step_d = STEP_4;
        STEP_4:  step_d = STEP_5;
        STEP_5:  step_d = STEP_6;
        STEP_6: begin
          step_d   = STEP_1;
          msg_done = 1'b1;
        end
        default: step_d = STEP_1;
      endcase
    end
  end

  // Assembler step register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_q <= STEP_1;
    else      step_q <= step_d;
  end

  // Staging registers: each step latches its truncated field; reset word discards all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_msg_type <= '0;
      stg_block_x  <= '0;
      stg_block_y  <= '0;
      stg_card     <= '0;
      stg_sel_len  <= '0;
    end else if (is_rst_word) begin
      stg_msg_type <= '0;
      stg_block_x  <= '0;
      stg_block_y  <= '0;
      stg_card     <= '0;
      stg_sel_len  <= '0;
    end else if (word_valid) begin
      case (step_q)
        STEP_1:  stg_msg_type <= word[MSG_W-1:0];
        STEP_2:  stg_block_x  <= word[BX_W-1:0];
        STEP_3:  stg_block_y  <= word[BY_W-1:0];
        STEP_4:  stg_card     <= word[CARD_W-1:0];
        STEP_5:  stg_sel_len  <= word[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // Output registers: move_dir bypasses staging since it arrives with the final word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recv_valid    <= 1'b0;
      remote_rst    <= 1'b0;
      recv_msg_type <= '0;
      recv_block_x  <= '0;
      recv_block_y  <= '0;
      recv_card     <= '0;
      recv_sel_len  <= '0;
      recv_move_dir <= 1'b0;
    end else begin
      recv_valid <= msg_done;
      remote_rst <= is_rst_word;
      if (msg_done) begin
        recv_msg_type <= stg_msg_type;
        recv_block_x  <= stg_block_x;
        recv_block_y  <= stg_block_y;
        recv_card     <= stg_card;
        recv_sel_len  <= stg_sel_len;
        recv_move_dir <= word[0];
      end
    end
  end

endmodule

// File: tb/tb_receive_all.sv
// Self-checking bench for receive_all: directed link scenarios plus randomized traffic.
module tb_receive_all;
  import receive_all_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Request;
  logic [5:0]  interboard_data;
  logic        Ack;
  logic        recv_valid;
  logic [3:0]  recv_msg_type;
  logic [4:0]  recv_block_x;
  logic [2:0]  recv_block_y;
  logic [5:0]  recv_card;
  logic [2:0]  recv_sel_len;
  logic        recv_move_dir;
  logic        remote_rst;

  always #5 clk = ~clk;

  receive_all #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Request        (Request),
    .interboard_data(interboard_data),
    .Ack            (Ack),
    .recv_valid     (recv_valid),
    .recv_msg_type  (recv_msg_type),
    .recv_block_x   (recv_block_x),
    .recv_block_y   (recv_block_y),
    .recv_card      (recv_card),
    .recv_sel_len   (recv_sel_len),
    .recv_move_dir  (recv_move_dir),
    .remote_rst     (remote_rst)
  );

  typedef struct {
    int unsigned mt, bx, by, card, len, dir;
  } msg_t;

  msg_t        exp_q[$];
  msg_t        got_q[$];
  msg_t        last_exp;
  int unsigned partial[$];
  int unsigned exp_rrst = 0, got_rrst = 0, ack_rises = 0;
  int unsigned n_vec = 0, n_err = 0;
  logic        ack_prev = 1'b0;
  bit          have_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observe the GameControl side and the Ack line.
  always @(negedge clk) begin
    msg_t m;
    if (rst) begin
      if (recv_valid) begin
        m.mt = recv_msg_type; m.bx = recv_block_x; m.by = recv_block_y;
        m.card = recv_card; m.len = recv_sel_len; m.dir = recv_move_dir;
        got_q.push_back(m);
      end
      if (remote_rst) got_rrst++;
      if (Ack && !ack_prev) ack_rises++;
    end
    ack_prev = Ack;
  end

  // Reference: words group into messages of six; 63 aborts the partial message.
  task automatic model_word(input int unsigned w);
    msg_t m;
    if (w == 63) begin
      exp_rrst++;
      partial.delete();
    end else begin
      partial.push_back(w);
      if (partial.size() == 6) begin
        m.mt = partial[0] % 16; m.bx = partial[1] % 32; m.by = partial[2] % 8;
        m.card = partial[3]; m.len = partial[4] % 8; m.dir = partial[5] % 2;
        exp_q.push_back(m);
        partial.delete();
      end
    end
  endtask

  // Peer sender: one 4-phase handshake; returns cycles to Ack rise and to Ack fall.
  task automatic send_word(input int unsigned w, input int unsigned hold, input int unsigned gap,
                           output int unsigned rise_cyc, output int unsigned fall_cyc);
    @(posedge clk); #1;
    interboard_data = w[5:0];
    Request = 1'b1;
    rise_cyc = 0;
    for (int i = 1; i <= 40 && rise_cyc == 0; i++) begin
      @(posedge clk); #1;
      if (Ack) rise_cyc = i;
    end
    if (rise_cyc == 0) check("ack_rise_timeout", 0, 1);
    repeat (hold) @(posedge clk);
    if (hold != 0) #1;
    Request = 1'b0;
    fall_cyc = 0;
    for (int i = 1; i <= 40 && fall_cyc == 0; i++) begin
      @(posedge clk); #1;
      if (!Ack) fall_cyc = i;
    end
    if (fall_cyc == 0) check("ack_fall_timeout", 0, 1);
    model_word(w);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_simple(input int unsigned w, input int unsigned gap);
    int unsigned r, f;
    send_word(w, (w == 63) ? 10 : 0, gap, r, f);
  endtask

  task automatic glitch();
    bit seen = 0;
    @(posedge clk); #1; Request = 1'b1;
    @(posedge clk); #1; Request = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (Ack) seen = 1;
    end
    check("glitch_no_ack", seen, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, Ack, 0);
    check({tag, "_valid"}, recv_valid, 0);
    check({tag, "_rrst"}, remote_rst, 0);
    check({tag, "_fields"}, {recv_msg_type, recv_block_x, recv_block_y, recv_card,
                             recv_sel_len, recv_move_dir}, 0);
  endtask

  // Compare observed traffic against the reference, then clear both sides.
  task automatic check_msgs(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_msg_count"}, got_q.size(), exp_q.size());
    check({tag, "_rrst_count"}, got_rrst, exp_rrst);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_m%0d_type", tag, i), got_q[i].mt, exp_q[i].mt);
      check($sformatf("%s_m%0d_bx", tag, i), got_q[i].bx, exp_q[i].bx);
      check($sformatf("%s_m%0d_by", tag, i), got_q[i].by, exp_q[i].by);
      check($sformatf("%s_m%0d_card", tag, i), got_q[i].card, exp_q[i].card);
      check($sformatf("%s_m%0d_len", tag, i), got_q[i].len, exp_q[i].len);
      check($sformatf("%s_m%0d_dir", tag, i), got_q[i].dir, exp_q[i].dir);
    end
    if (exp_q.size() > 0) begin
      last_exp = exp_q[exp_q.size() - 1];
      have_last = 1;
    end
    if (have_last) begin
      check({tag, "_hold"}, {recv_msg_type, recv_block_x, recv_block_y, recv_card,
                             recv_sel_len, recv_move_dir},
            {last_exp.mt[3:0], last_exp.bx[4:0], last_exp.by[2:0], last_exp.card[5:0],
             last_exp.len[2:0], last_exp.dir[0]});
    end
    exp_q.delete();
    got_q.delete();
    exp_rrst = 0;
    got_rrst = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned r, f, a0, w, inject_at, n_words;
    int unsigned words1[6];
    int unsigned words2[6];
    words1 = '{5, 17, 3, 42, 4, 1};
    words2 = '{1, 0, 0, 10, 1, 0};

    rst = 1'b0;
    Request = 1'b0;
    interboard_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full message with exact handshake timing on every word.
    a0 = ack_rises;
    foreach (words1[i]) begin
      send_word(words1[i], 0, 2, r, f);
      check($sformatf("rise_lat_w%0d", i), r, 5);
      check($sformatf("fall_lat_w%0d", i), f, 3);
    end
    check_msgs("full");
    check("ack_pulses", ack_rises - a0, 6);

    // Short Request glitch is ignored and the assembler stays at the first step.
    a0 = ack_rises;
    glitch();
    check("glitch_ack_count", ack_rises - a0, 0);
    foreach (words2[i]) send_simple(words2[i], 1);
    check_msgs("after_glitch");

    // Reset word mid-message, then a clean message.
    send_simple(2, 1);
    send_simple(9, 1);
    send_simple(63, 1);
    check("rrst_pulse", got_rrst, 1);
    check("rrst_no_valid", got_q.size(), 0);
    foreach (words2[i]) send_simple(words2[i], 1);
    check_msgs("reset_word");

    // Back-to-back messages, Request re-raised one cycle after Ack falls.
    foreach (words1[i]) send_simple(words1[i], 0);
    send_simple(12, 0); send_simple(3, 0); send_simple(6, 0);
    send_simple(55, 0); send_simple(2, 0); send_simple(0, 0);
    check_msgs("b2b");

    // Local reset while Ack is high.
    send_simple(9, 1);
    @(posedge clk); #1;
    interboard_data = 6'd3;
    Request = 1'b1;
    r = 0;
    for (int i = 1; i <= 40 && r == 0; i++) begin
      @(posedge clk); #1;
      if (Ack) r = i;
    end
    check("lrst_ack_seen", r, 5);
    #2 rst = 1'b0;
    #1;
    check_outputs_zero("local_rst");
    Request = 1'b0;
    partial.delete();
    have_last = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    send_simple(7, 1); send_simple(31, 1); send_simple(7, 1);
    send_simple(0, 1); send_simple(7, 1); send_simple(1, 1);
    check_msgs("after_lrst");

    // Randomized traffic: random fields, holds, gaps, glitches and reset words.
    for (int m = 0; m < 25; m++) begin
      inject_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 99;
      n_words = 6;
      for (int i = 0; i < n_words; i++) begin
        if ($urandom_range(0, 9) == 0) glitch();
        if (i == inject_at) begin
          send_simple(63, $urandom_range(0, 3));
          inject_at = 99;
          n_words = i + 7;
        end
        w = $urandom_range(0, 62);
        send_word(w, $urandom_range(0, 2), $urandom_range(0, 3), r, f);
      end
      if (m % 5 == 4) check_msgs($sformatf("rand%0d", m));
    end
    check_msgs("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/receive_all.md
Name: receive_all

Overview:
- Receiving end of the interboard Request/Ack link; sits between the interboard pins and GameControl.
- Completes the 4-phase handshake for each 6-bit word sent by the peer board's sender.
- Assembles six consecutive words (msg_type, block_x, block_y, card, sel_len, move_dir) into one message and presents it to GameControl with a one-cycle valid pulse.
- Detects the peer's interboard reset word and reports it.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous Request input (minimum 2).
- SETTLE_CYCLES, 2, cycles Request must read high after synchronisation before interboard_data is sampled.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- Request  in  1  from peer board, asynchronous
- interboard_data  in  6  from peer board; stable while Request is high
- Ack  out  1  to peer board
- recv_valid  out  1  one-cycle pulse: the recv_* outputs hold a complete new message
- recv_msg_type  out  4  word 1, bits [3:0]
- recv_block_x  out  5  word 2, bits [4:0]
- recv_block_y  out  3  word 3, bits [2:0]
- recv_card  out  6  word 4
- recv_sel_len  out  3  word 5, bits [2:0]
- recv_move_dir  out  1  word 6, bit [0]
- remote_rst  out  1  one-cycle pulse: the peer sent its interboard reset word

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, both FSMs are in their idle state, and the synchroniser is cleared.
- Single-word responder FSM (receive_single). Let req_s be the synchronised Request.
  - WAIT_REQ_UP: Ack=0. When req_s has been 1 for SETTLE_CYCLES consecutive cycles, capture interboard_data into word_reg and go to ACK_HIGH.
  - ACK_HIGH: Ack=1 (registered). Emit word_valid for one cycle on entry. When req_s=0, go to ACK_LOW.
  - ACK_LOW: Ack=0. Return to WAIT_REQ_UP on the next cycle.
  - A Request glitch shorter than SETTLE_CYCLES is ignored; the settle counter clears whenever req_s=0.
- Message assembler FSM: states STEP_1..STEP_6, advancing on each word_valid.
  - Each step latches its word, truncated to the field width, into a staging register.
  - On STEP_6 word_valid: copy all staging registers to the recv_* outputs in the same cycle, pulse recv_valid on the next cycle, and return to STEP_1.
  - recv_* outputs hold their value until the next complete message.
- Latency: from Request rising at the pin, Ack rises SYNC_STAGES+SETTLE_CYCLES+1 cycles later, i.e. 5 cycles at the defaults.
- Interboard reset:
  - A word equal to 6'h3F at any step is the reset word. Card value 63 is reserved and is never sent as data.
  - On the reset word: pulse remote_rst, discard the staging registers, force the assembler to STEP_1, and do not pulse recv_valid.
  - The responder still completes the handshake. The peer holds Request high for about 10 cycles and then drops it when its own delayed reset clears.
- Repeated 3F words, including one re-captured after the handshake completes, each pulse remote_rst again. This is harmless.
- A partial message interrupted by the reset word is lost. No timeout exists; a peer that stalls mid-message leaves the assembler waiting indefinitely.
- Local rst asserted mid-handshake: Ack drops immediately (asynchronously). The peer's sender then waits in its wait-for-Ack state until the link is re-established. This is accepted.

Decomposition:
- Shared package holds:
  - step localparams STEP_1..STEP_6 (shared with the sender);
  - RST_WORD = 6'h3F;
  - field widths MSG_W=4, BX_W=5, BY_W=3, CARD_W=6, LEN_W=3.
- One sub-module, receive_single: synchroniser, settle counter, responder FSM and word_reg, with outputs word_valid and word.
- receive_all instantiates receive_single and contains the assembler, the staging registers and the output registers.

Test Plan:
- Full message: words 5, 17, 3, 42, 4, 1, each with a standard 4-phase handshake → one recv_valid pulse with msg_type=5, block_x=17, block_y=3, card=42, sel_len=4, move_dir=1; exactly six Ack pulses.
- Handshake timing: Request rises at cycle 0 → Ack=1 at cycle 5. Request falls → Ack falls 3 cycles later (2 sync cycles + 1). No Ack while Request is low.
- Glitch: Request high for 1 cycle → no Ack, no capture, assembler still at STEP_1.
- Reset word mid-message: words 2, 9, 6'h3F → remote_rst pulses once and recv_valid does not pulse. A following full message 1, 0, 0, 10, 1, 0 yields recv_valid with exactly those fields.
- Back-to-back messages with the peer re-raising Request 1 cycle after Ack falls → two recv_valid pulses, the second carrying the new values; no dropped words.
- Local rst pulsed low while in ACK_HIGH → Ack=0 and all recv_* outputs = 0 immediately. The next full message (7, 31, 7, 0, 7, 1) is received correctly.
